// File: rtl/qspi_psram_responder.sv
// qspi_psram_responder
// Memory end of a QSPI PSRAM bus (APS6404 subset: 0x35 enter QPI, 0xF5 exit
// QPI, 0xEB quad read, 0x38 quad write), backed by a byte-wide RAM port.
// sck and ce_n are oversampled by clk (clk must be >= 4x sck); nothing is
// clocked on sck. Inputs are sampled on sck rises, outputs change on falls.
//
// Ports
//   clk, rst          system clock, asynchronous active-high reset
//   ce_n, sck, dio_in initiator chip enable, SPI clock (mode 0), io[3:0] in
//   dio_out, dio_oe   io[3:0] output data and enables (1 = drive)
//   mem_addr          backing RAM byte address (wraps modulo 2**MEM_AW)
//   mem_wdata, mem_we one-clk write strobe with data
//   mem_re, mem_rdata one-clk read strobe; mem_rdata valid on the next clk
//   qpi_mode          1 = command phase uses all four lines
module qspi_psram_responder #(
  parameter int MEM_AW      = 16,
  parameter int WAIT_CYCLES = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ce_n,
  input  logic              sck,
  input  logic [3:0]        dio_in,
  output logic [3:0]        dio_out,
  output logic [3:0]        dio_oe,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [7:0]        mem_rdata,
  output logic              qpi_mode
);

  typedef enum logic [2:0] {IDLE, CMD, ADDR, WAIT, RDATA, WDATA, IGNORE} state_t;

  localparam logic [7:0] WAIT_LAST = 8'(WAIT_CYCLES);

  state_t     state, state_nxt;
  logic       ce_s1, ce_s2, ce_d;
  logic       sck_s1, sck_s2, sck_d;
  logic [3:0] dio_s1, dio_s2;
  logic       sck_rise, sck_fall, ce_fall;
  logic [7:0] cnt;       // bits / nibbles / dummy rises within the current state
  logic [7:0] sh;        // opcode, write byte, or read byte being presented
  logic [7:0] pf;        // prefetched next read byte
  logic       is_write;
  logic       nib_lo;    // next nibble in the current byte is the low one
  logic       rd_pend;   // mem_rdata carries the result of last clk's mem_re
  logic [7:0] spi_op, qpi_op;
  logic       cmd_last, addr_last, wait_last;

  assign sck_rise  = sck_s2 & ~sck_d;
  assign sck_fall  = ~sck_s2 & sck_d;
  assign ce_fall   = ce_d & ~ce_s2;
  assign spi_op    = {sh[6:0], dio_s2[0]};
  assign qpi_op    = {sh[3:0], dio_s2};
  assign cmd_last  = sck_rise && (cnt == (qpi_mode ? 8'd1 : 8'd7));
  assign addr_last = sck_rise && (cnt == 8'd5);
  assign wait_last = sck_fall && (cnt == WAIT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ce_s1  <= 1'b1;
      ce_s2  <= 1'b1;
      ce_d   <= 1'b1;
      sck_s1 <= 1'b0;
      sck_s2 <= 1'b0;
      sck_d  <= 1'b0;
      dio_s1 <= '0;
      dio_s2 <= '0;
      state  <= IDLE;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge value of its neighbours, like real hardware.
      ce_s1  <= ce_n;
      ce_s2  <= ce_s1;
      ce_d   <= ce_s2;
      sck_s1 <= sck;
      sck_s2 <= sck_s1;
      sck_d  <= sck_s2;
      dio_s1 <= dio_in;
      dio_s2 <= dio_s1;
      state  <= state_nxt;
    end
  end

  always_comb begin
    // NOTE: assigning the default first keeps every path driven, so no latch.
    state_nxt = state;
    if (ce_s2) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:  if (ce_fall) state_nxt = CMD;
        CMD:   if (cmd_last) begin
                 if (qpi_mode && (qpi_op == 8'hEB || qpi_op == 8'h38)) state_nxt = ADDR;
                 else state_nxt = IGNORE;
               end
        ADDR:  if (addr_last) state_nxt = is_write ? WDATA : WAIT;
        WAIT:  if (wait_last) state_nxt = RDATA;
        default: state_nxt = state;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dio_out   <= '0;
      dio_oe    <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_we    <= 1'b0;
      mem_re    <= 1'b0;
      qpi_mode  <= 1'b0;
      cnt       <= '0;
      sh        <= '0;
      pf        <= '0;
      is_write  <= 1'b0;
      nib_lo    <= 1'b0;
      rd_pend   <= 1'b0;
    end else begin
      mem_we  <= 1'b0;
      mem_re  <= 1'b0;
      rd_pend <= mem_re;
      // Write address advances while the strobe is high, so the RAM sees
      // the pre-increment address with the data.
      if (mem_we) mem_addr <= mem_addr + MEM_AW'(1);

      if (ce_s2) begin
        dio_oe  <= '0;
        rd_pend <= 1'b0;
        nib_lo  <= 1'b0;
      end else begin
        case (state)
          CMD: if (sck_rise) begin
            sh  <= qpi_mode ? qpi_op : spi_op;
            cnt <= cnt + 8'd1;
            if (cmd_last) begin
              if (!qpi_mode) begin
                if (spi_op == 8'h35) qpi_mode <= 1'b1;
              end else begin
                if (qpi_op == 8'hF5) qpi_mode <= 1'b0;
                is_write <= (qpi_op == 8'h38);
              end
            end
          end
          ADDR: if (sck_rise) begin
            // Upper address bits fall off the top of the shift.
            mem_addr <= {mem_addr[MEM_AW-5:0], dio_s2};
            cnt      <= cnt + 8'd1;
            if (addr_last && !is_write) mem_re <= 1'b1;
          end
          WAIT: begin
            if (rd_pend)  sh  <= mem_rdata;
            if (sck_rise) cnt <= cnt + 8'd1;
            if (wait_last) begin
              dio_oe   <= 4'hF;
              dio_out  <= sh[7:4];
              nib_lo   <= 1'b1;
              mem_addr <= mem_addr + MEM_AW'(1);
              mem_re   <= 1'b1;
            end
          end
          RDATA: begin
            if (rd_pend) pf <= mem_rdata;
            if (sck_fall) begin
              if (!nib_lo) begin
                dio_out  <= sh[7:4];
                nib_lo   <= 1'b1;
                mem_addr <= mem_addr + MEM_AW'(1);
                mem_re   <= 1'b1;
              end else begin
                dio_out <= sh[3:0];
                sh      <= pf;
                nib_lo  <= 1'b0;
              end
            end
          end
          WDATA: if (sck_rise) begin
            sh     <= qpi_op;
            nib_lo <= ~nib_lo;
            if (nib_lo) begin
              mem_wdata <= qpi_op;
              mem_we    <= 1'b1;
            end
          end
          default: dio_oe <= '0;
        endcase
      end

      if (state_nxt != state) cnt <= '0;
    end
  end

endmodule
